// File: rtl/pipelined_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decode_stage_if
// Purpose  : IF/ID input, writeback and ID/EX output bundle of the decode stage.
// Revision : 1.0
// ============================================================================
interface pipelined_decode_stage_if #(
   parameter int XLEN = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             wb_en;
   logic [4:0]       wb_rd;
   logic [XLEN-1:0]  wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [6:0]       out_opcode;
   logic [2:0]       out_fn3;
   logic [6:0]       out_fn7;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [4:0]       out_rd;
   logic [XLEN-1:0]  out_rs1_val;
   logic [XLEN-1:0]  out_rs2_val;
   logic [XLEN-1:0]  out_imm;
   logic             out_alu_src;
   logic             out_reg_write;
   logic             out_is_load;
   logic             out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_pc, out_opcode, out_fn3, out_fn7,
             out_rs1, out_rs2, out_rd, out_rs1_val, out_rs2_val, out_imm,
             out_alu_src, out_reg_write, out_is_load, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_pc, out_opcode, out_fn3, out_fn7,
             out_rs1, out_rs2, out_rd, out_rs1_val, out_rs2_val, out_imm,
             out_alu_src, out_reg_write, out_is_load, out_illegal
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decode_stage
// Purpose  : RV32I/E decode stage with register file, WB bypass, load-use stall.
// Revision : 1.0
// ============================================================================
module pipelined_decode_stage #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   pipelined_decode_stage_if.slave  bus
);
   localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [5:0] c_NREGS = 6'(NREGS);

   logic [XLEN-1:0] rf_q [NREGS];

   logic            out_valid_q;
   logic [XLEN-1:0] out_pc_q, out_rs1_val_q, out_rs2_val_q, out_imm_q;
   logic [6:0]      out_opcode_q, out_fn7_q;
   logic [2:0]      out_fn3_q;
   logic [4:0]      out_rs1_q, out_rs2_q, out_rd_q;
   logic            out_alu_src_q, out_reg_write_q, out_is_load_q, out_illegal_q;

   logic [6:0]      opcode_d, fn7_d;
   logic [2:0]      fn3_d;
   logic [4:0]      rs1_d, rs2_d, rd_d;
   logic [XLEN-1:0] rs1_val_d, rs2_val_d, imm_d;
   logic            alu_src_d, reg_write_d, is_load_d, illegal_d;
   logic            use1, use2;
   logic            is_r, is_i, is_s, is_b, is_u, is_j, use_rd;
   logic signed [31:0] imm32;
   logic            adv, haz, in_ready_w;

   function automatic logic idx_ok(input logic [4:0] idx);
      return ({1'b0, idx} < c_NREGS);
   endfunction

   // Operand read: x0 and out-of-range indices read zero; same-cycle WB is forwarded.
   function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx);
      if (idx == 5'd0 || !idx_ok(idx))
         return '0;
      if (BYPASS != 0 && bus.wb_en && bus.wb_rd == idx)
         return bus.wb_data;
      return rf_q[idx[AW-1:0]];
   endfunction

   always_comb begin
      opcode_d = bus.in_instr[6:0];
      rd_d     = bus.in_instr[11:7];
      fn3_d    = bus.in_instr[14:12];
      rs1_d    = bus.in_instr[19:15];
      rs2_d    = bus.in_instr[24:20];
      fn7_d    = bus.in_instr[31:25];

      is_r = (opcode_d == 7'b0110011);
      is_i = (opcode_d == 7'b0000011) || (opcode_d == 7'b0010011) ||
             (opcode_d == 7'b1100111) || (opcode_d == 7'b1110011);
      is_s = (opcode_d == 7'b0100011);
      is_b = (opcode_d == 7'b1100011);
      is_u = (opcode_d == 7'b0110111) || (opcode_d == 7'b0010111);
      is_j = (opcode_d == 7'b1101111);

      use1   = is_r | is_i | is_s | is_b;
      use2   = is_r | is_s | is_b;
      use_rd = is_r | is_i | is_u | is_j;

      illegal_d = !(is_r | is_i | is_s | is_b | is_u | is_j) ||
                  (use1 && !idx_ok(rs1_d)) || (use2 && !idx_ok(rs2_d)) ||
                  (use_rd && !idx_ok(rd_d));

      imm32 = '0;
      if (is_i)
         imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      else if (is_s)
         imm32 = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      else if (is_b)
         imm32 = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                  bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      else if (is_u)
         imm32 = {bus.in_instr[31:12], 12'b0};
      else if (is_j)
         imm32 = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                  bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      imm_d = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

      alu_src_d   = !(is_r | is_b);
      reg_write_d = use_rd && (rd_d != 5'd0) && !illegal_d;
      is_load_d   = (opcode_d == 7'b0000011);

      rs1_val_d = read_reg(rs1_d);
      rs2_val_d = read_reg(rs2_d);

      adv = !out_valid_q || bus.out_ready;
      haz = out_valid_q && out_is_load_q && (out_rd_q != 5'd0) &&
            ((use1 && rs1_d == out_rd_q) || (use2 && rs2_d == out_rd_q));
      in_ready_w = adv && !haz && !flush && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            rf_q[i] <= '0;
         out_valid_q     <= 1'b0;
         out_pc_q        <= '0;
         out_opcode_q    <= '0;
         out_fn3_q       <= '0;
         out_fn7_q       <= '0;
         out_rs1_q       <= '0;
         out_rs2_q       <= '0;
         out_rd_q        <= '0;
         out_rs1_val_q   <= '0;
         out_rs2_val_q   <= '0;
         out_imm_q       <= '0;
         out_alu_src_q   <= 1'b0;
         out_reg_write_q <= 1'b0;
         out_is_load_q   <= 1'b0;
         out_illegal_q   <= 1'b0;
      end else begin
         // Writeback is independent of stall, backpressure and flush.
         if (bus.wb_en && bus.wb_rd != 5'd0 && idx_ok(bus.wb_rd))
            rf_q[bus.wb_rd[AW-1:0]] <= bus.wb_data;

         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (adv) begin
            if (haz || !bus.in_valid) begin
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q     <= 1'b1;
               out_pc_q        <= bus.in_pc;
               out_opcode_q    <= opcode_d;
               out_fn3_q       <= fn3_d;
               out_fn7_q       <= fn7_d;
               out_rs1_q       <= rs1_d;
               out_rs2_q       <= rs2_d;
               out_rd_q        <= rd_d;
               out_rs1_val_q   <= rs1_val_d;
               out_rs2_val_q   <= rs2_val_d;
               out_imm_q       <= imm_d;
               out_alu_src_q   <= alu_src_d;
               out_reg_write_q <= reg_write_d;
               out_is_load_q   <= is_load_d;
               out_illegal_q   <= illegal_d;
            end
         end
      end
   end

   assign bus.in_ready      = in_ready_w;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_pc        = out_pc_q;
   assign bus.out_opcode    = out_opcode_q;
   assign bus.out_fn3       = out_fn3_q;
   assign bus.out_fn7       = out_fn7_q;
   assign bus.out_rs1       = out_rs1_q;
   assign bus.out_rs2       = out_rs2_q;
   assign bus.out_rd        = out_rd_q;
   assign bus.out_rs1_val   = out_rs1_val_q;
   assign bus.out_rs2_val   = out_rs2_val_q;
   assign bus.out_imm       = out_imm_q;
   assign bus.out_alu_src   = out_alu_src_q;
   assign bus.out_reg_write = out_reg_write_q;
   assign bus.out_is_load   = out_is_load_q;
   assign bus.out_illegal   = out_illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_decode_stage
// Purpose  : Directed bench; three instances (default, no bypass, RV32E) share stimulus.
// Revision : 1.0
// ============================================================================
module tb_pipelined_decode_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        out_ready = 1'b1;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   localparam logic [31:0] ADD  = 32'h002081B3;  // add x3,x1,x2
   localparam logic [31:0] LB   = 32'h00308383;  // lb x7,3(x1)
   localparam logic [31:0] AND_ = 32'h0013F333;  // and x6,x7,x1
   localparam logic [31:0] ADDI = 32'hFFF00093;  // addi x1,x0,-1
   localparam logic [31:0] BEQ  = 32'hFE208EE3;  // beq x1,x2,-4
   localparam logic [31:0] ADD17 = 32'h002088B3; // add x17,x1,x2
   localparam logic [31:0] ADD20 = 32'h000A01B3; // add x3,x20,x0

   pipelined_decode_stage_if #(.XLEN(32)) if_a ();
   pipelined_decode_stage_if #(.XLEN(32)) if_b ();
   pipelined_decode_stage_if #(.XLEN(32)) if_c ();

   assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;  assign if_c.in_valid = in_valid;
   assign if_a.in_instr = in_instr;  assign if_b.in_instr = in_instr;  assign if_c.in_instr = in_instr;
   assign if_a.in_pc    = in_pc;     assign if_b.in_pc    = in_pc;     assign if_c.in_pc    = in_pc;
   assign if_a.wb_en    = wb_en;     assign if_b.wb_en    = wb_en;     assign if_c.wb_en    = wb_en;
   assign if_a.wb_rd    = wb_rd;     assign if_b.wb_rd    = wb_rd;     assign if_c.wb_rd    = wb_rd;
   assign if_a.wb_data  = wb_data;   assign if_b.wb_data  = wb_data;   assign if_c.wb_data  = wb_data;
   assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready; assign if_c.out_ready = out_ready;

   pipelined_decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .bus(if_a.slave));
   pipelined_decode_stage #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .bus(if_b.slave));
   pipelined_decode_stage #(.XLEN(32), .NREGS(16), .BYPASS(1)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .bus(if_c.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] rd, input logic [31:0] data);
      wb_en = 1'b1; wb_rd = rd; wb_data = data;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0;
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAA;   // must be ignored under reset
      tick(); tick();
      total_cnt++; if (if_a.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0h required 0", if_a.in_ready); else pass_cnt++;
      total_cnt++; if (if_a.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0h required 0", if_a.out_valid); else pass_cnt++;
      total_cnt++; if (if_a.out_imm !== 32'h0 || if_a.out_pc !== 32'h0) $display("FAIL rst_out_fields: got imm %h pc %h required 0", if_a.out_imm, if_a.out_pc); else pass_cnt++;
      wb_en = 1'b0; reset = 1'b0;
      #1;
      total_cnt++; if (if_a.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %0h required 1", if_a.in_ready); else pass_cnt++;
   endtask

   task automatic test_add();
      write_reg(5'd1, 32'd5);
      write_reg(5'd2, 32'd7);
      in_valid = 1'b1; in_instr = ADD; in_pc = 32'h100;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_rd !== 5'd3) $display("FAIL add_valid_rd: got %0h/%0d required 1/3", if_a.out_valid, if_a.out_rd); else pass_cnt++;
      total_cnt++; if (if_a.out_rs1_val !== 32'd5 || if_a.out_rs2_val !== 32'd7) $display("FAIL add_operands: got %0d/%0d required 5/7", if_a.out_rs1_val, if_a.out_rs2_val); else pass_cnt++;
      total_cnt++; if (if_a.out_imm !== 32'h0 || if_a.out_alu_src !== 1'b0 || if_a.out_reg_write !== 1'b1) $display("FAIL add_ctrl: got imm %h alu_src %0h reg_write %0h required 0/0/1", if_a.out_imm, if_a.out_alu_src, if_a.out_reg_write); else pass_cnt++;
      total_cnt++; if (if_a.out_pc !== 32'h100 || if_a.out_opcode !== 7'h33) $display("FAIL add_pc_opcode: got %h/%h required 100/33", if_a.out_pc, if_a.out_opcode); else pass_cnt++;
      tick();
      total_cnt++; if (if_a.out_valid !== 1'b0) $display("FAIL idle_out_valid: got %0h required 0", if_a.out_valid); else pass_cnt++;
   endtask

   task automatic test_load_use();
      in_valid = 1'b1; in_instr = LB; in_pc = 32'h110;
      tick();
      total_cnt++; if (if_a.out_is_load !== 1'b1 || if_a.out_imm !== 32'd3 || if_a.out_rd !== 5'd7) $display("FAIL lb_decode: got load %0h imm %h rd %0d required 1/3/7", if_a.out_is_load, if_a.out_imm, if_a.out_rd); else pass_cnt++;
      in_instr = AND_; in_pc = 32'h114;
      #1;
      total_cnt++; if (if_a.in_ready !== 1'b0) $display("FAIL hazard_in_ready: got %0h required 0", if_a.in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (if_a.out_valid !== 1'b0) $display("FAIL hazard_bubble: got %0h required 0", if_a.out_valid); else pass_cnt++;
      total_cnt++; if (if_a.in_ready !== 1'b1) $display("FAIL hazard_clear: got %0h required 1", if_a.in_ready); else pass_cnt++;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_rd !== 5'd6 || if_a.out_fn3 !== 3'b111 || if_a.out_rs2_val !== 32'd5) $display("FAIL and_issue: got v %0h rd %0d fn3 %0h rs2v %0d required 1/6/7/5", if_a.out_valid, if_a.out_rd, if_a.out_fn3, if_a.out_rs2_val); else pass_cnt++;
      tick();
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
      in_valid = 1'b1; in_instr = ADD; in_pc = 32'h120;
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      total_cnt++; if (if_a.out_rs1_val !== 32'hDEADBEEF) $display("FAIL bypass_on: got %h required deadbeef", if_a.out_rs1_val); else pass_cnt++;
      total_cnt++; if (if_b.out_rs1_val !== 32'd5) $display("FAIL bypass_off: got %h required 5", if_b.out_rs1_val); else pass_cnt++;
      tick();
   endtask

   task automatic test_back_to_back_imm();
      in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h130;
      tick();
      total_cnt++; if (if_a.out_imm !== 32'hFFFFFFFF || if_a.out_alu_src !== 1'b1) $display("FAIL addi_imm: got %h alu_src %0h required ffffffff/1", if_a.out_imm, if_a.out_alu_src); else pass_cnt++;
      in_instr = BEQ; in_pc = 32'h134;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (if_a.out_imm !== 32'hFFFFFFFC || if_a.out_reg_write !== 1'b0 || if_a.out_alu_src !== 1'b0) $display("FAIL beq_imm: got %h rw %0h alu_src %0h required fffffffc/0/0", if_a.out_imm, if_a.out_reg_write, if_a.out_alu_src); else pass_cnt++;
      total_cnt++; if (if_a.out_pc !== 32'h134 || if_a.out_valid !== 1'b1) $display("FAIL beq_pc: got %h v %0h required 134/1", if_a.out_pc, if_a.out_valid); else pass_cnt++;
      tick();
   endtask

   task automatic test_backpressure_flush();
      in_valid = 1'b1; in_instr = ADD; in_pc = 32'h200;
      tick();
      out_ready = 1'b0; in_instr = BEQ; in_pc = 32'h204;
      #1;
      total_cnt++; if (if_a.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0h required 0", if_a.in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_pc !== 32'h200 || if_a.out_rd !== 5'd3 || if_a.out_rs1_val !== 32'hDEADBEEF) $display("FAIL bp_hold: got v %0h pc %h rd %0d rs1v %h required 1/200/3/deadbeef", if_a.out_valid, if_a.out_pc, if_a.out_rd, if_a.out_rs1_val); else pass_cnt++;
      flush = 1'b1;
      #1;
      total_cnt++; if (if_a.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %0h required 0", if_a.in_ready); else pass_cnt++;
      tick();
      flush = 1'b0;
      total_cnt++; if (if_a.out_valid !== 1'b0 || if_a.out_pc !== 32'h200) $display("FAIL flush_kill: got v %0h pc %h required 0/200", if_a.out_valid, if_a.out_pc); else pass_cnt++;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
   endtask

   task automatic test_rv32e_and_reset();
      in_valid = 1'b1; in_instr = ADD17; in_pc = 32'h300;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (if_c.out_illegal !== 1'b1 || if_c.out_reg_write !== 1'b0 || if_c.out_valid !== 1'b1) $display("FAIL e_illegal: got ill %0h rw %0h v %0h required 1/0/1", if_c.out_illegal, if_c.out_reg_write, if_c.out_valid); else pass_cnt++;
      total_cnt++; if (if_a.out_illegal !== 1'b0 || if_a.out_reg_write !== 1'b1) $display("FAIL i_legal: got ill %0h rw %0h required 0/1", if_a.out_illegal, if_a.out_reg_write); else pass_cnt++;
      write_reg(5'd20, 32'h1234);
      in_valid = 1'b1; in_instr = ADD20; in_pc = 32'h304;
      tick();
      total_cnt++; if (if_c.out_rs1_val !== 32'h0) $display("FAIL e_x20_dropped: got %h required 0", if_c.out_rs1_val); else pass_cnt++;
      total_cnt++; if (if_a.out_rs1_val !== 32'h1234) $display("FAIL i_x20_written: got %h required 1234", if_a.out_rs1_val); else pass_cnt++;
      in_instr = ADD; in_pc = 32'h308;
      tick();
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      total_cnt++; if (if_a.out_valid !== 1'b0 || if_a.out_rd !== 5'd0 || if_c.out_valid !== 1'b0) $display("FAIL midrst_out: got v %0h rd %0d ev %0h required 0/0/0", if_a.out_valid, if_a.out_rd, if_c.out_valid); else pass_cnt++;
      in_valid = 1'b1; in_instr = ADD; in_pc = 32'h30C;
      tick();
      in_valid = 1'b0;
      total_cnt++; if (if_a.out_rs1_val !== 32'h0 || if_a.out_rs2_val !== 32'h0 || if_c.out_rs2_val !== 32'h0) $display("FAIL midrst_regs: got %h/%h/%h required 0", if_a.out_rs1_val, if_a.out_rs2_val, if_c.out_rs2_val); else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_use();
      test_bypass();
      test_back_to_back_imm();
      test_backpressure_flush();
      test_rv32e_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
